difftest_step_scheduler: RTL and testbench
==========================================

// Module: difftest_step_scheduler
// PURPOSE
// Sequences the DUT's per-cycle commit-step output into batched check requests for the host-side
// difftest checker. Accumulates step counts, issues one outstanding request at a time over a
// valid/ready handshake, consumes the checker verdict, and enforces the cycle limit. Replaces
// per-cycle checker calls in the simulation top; sits between SimTop and the checker transactor.
// PARAMETERS
// STEP_WIDTH   8    width of per-cycle step input
// CNT_WIDTH    16   width of accumulated step count carried in a request
// TO_WIDTH     16   width of flush-timeout counter
// PORTS
// clock         in   1           clock
// reset         in   1           synchronous, active-low
// step_in       in   STEP_WIDTH  steps committed this cycle (already one-cycle delayed)
// max_cycles    in   64          cycle limit; 0 = unlimited; static after reset release
// batch_thresh  in   CNT_WIDTH   issue request when acc >= this; 0 treated as 1
// flush_timeout in   TO_WIDTH    issue partial batch after this many idle cycles; 0 = disabled
// init_valid    out  1           one-cycle pulse requesting checker init
// req_valid     out  1           batch request valid
// req_ready     in   1           checker accepts request
// req_count     out  CNT_WIDTH   steps in batch
// req_cycle     out  64          n_cycles at the request's issue
// rsp_valid     in   1           checker verdict valid (1-cycle pulse)
// rsp_code      in   32          0 = pass, 32'hFF = checkpoint limit reached, other = mismatch
// n_cycles      out  64          cycles since reset release
// done          out  1           sticky; simulation must finish
// done_cause    out  3           0 none,1 fail,2 gcpt_limit,3 max_cycles,4 acc_overflow
// BEHAVIOUR
// - Reset (reset==0): state INIT, all outputs 0, acc=0, timeout counter=0, n_cycles=0.
// - n_cycles increments every cycle out of reset until done; frozen after done.
// - FSM INIT -> RUN -> ISSUE -> WAIT_RSP -> RUN ... ; any state -> DONE (terminal).
//   INIT: first cycle after reset release, assert init_valid one cycle, go RUN.
//   RUN: acc <= acc + step_in. When acc_next >= max(batch_thresh,1), or flush_timeout!=0 and
//        idle counter reaches flush_timeout with acc_next!=0, latch req_count<=acc_next,
//        req_cycle<=n_cycles, acc<=0, go ISSUE.
//   ISSUE: req_valid=1; payload stable until req_valid&&req_ready; then WAIT_RSP.
//   WAIT_RSP: wait rsp_valid. rsp_code==0 -> RUN; 32'hFF -> DONE cause 2; else DONE cause 1.
// - Accumulation continues in ISSUE and WAIT_RSP (no step lost); only one request outstanding.
// - Idle counter: increments while acc!=0 and no issue; clears on issue or when acc==0.
// - acc arithmetic at CNT_WIDTH+1; if acc_next > 2^CNT_WIDTH-1 -> DONE cause 4.
// - max_cycles!=0 and n_cycles >= max_cycles -> DONE cause 3 (checked every non-DONE cycle).
// - Simultaneous events same cycle, priority: fail > gcpt_limit > acc_overflow > max_cycles.
// - rsp_valid outside WAIT_RSP ignored. req_ready while req_valid=0 ignored.
// - DONE: req_valid=0, init_valid=0, done=1, done_cause held until reset.
// - Reset mid-request: drops outstanding request, no completion; transactor flushes on reset.
// STRUCTURE
// - Package difftest_sched_pkg: state enum (INIT,RUN,ISSUE,WAIT_RSP,DONE), done_cause enum,
//   RSP_PASS=32'h0, RSP_GCPT=32'hFF.
// - One sub-module: difftest_step_accum (acc, idle timer, overflow flag, flush decision).
// - FSM, cycle counter and done logic in top module.
// TESTING
// - thresh=4, step_in=1 each cycle, req_ready=1, rsp pass after 2 cycles -> req_count=4 per batch,
//   step sum across requests equals total steps driven.
// - init check: release reset -> init_valid high exactly cycle 1, never again.
// - req_ready held 0 for 10 cycles with steps=2 -> req_valid/payload stable, acc grows to 20,
//   next batch carries 20 after response.
// - thresh=100, timeout=5, single step=3 then 0 -> request count=3 issued after 5 idle cycles.
// - rsp_code=32'hFF -> done=1, done_cause=2; rsp_code=5 -> cause 1; n_cycles frozen.
// - max_cycles=50, no responses -> done at n_cycles=50 cause 3; fail same cycle -> cause 1 wins.

Source files
------------

// File: rtl/difftest_sched_pkg.sv
// Shared types and response codes for the difftest step scheduler.
package difftest_sched_pkg;

    typedef enum logic [2:0] {
        ST_INIT     = 3'd0,
        ST_RUN      = 3'd1,
        ST_ISSUE    = 3'd2,
        ST_WAIT_RSP = 3'd3,
        ST_DONE     = 3'd4
    } sched_state_e;

    typedef enum logic [2:0] {
        CAUSE_NONE       = 3'd0,
        CAUSE_FAIL       = 3'd1,
        CAUSE_GCPT       = 3'd2,
        CAUSE_MAX_CYCLES = 3'd3,
        CAUSE_ACC_OVF    = 3'd4
    } done_cause_e;

    localparam logic [31:0] RSP_PASS = 32'h0000_0000;
    localparam logic [31:0] RSP_GCPT = 32'h0000_00FF;

endpackage

// File: rtl/difftest_step_accum.sv
// Step accumulator with idle timer; flags batch-ready (threshold or flush timeout) and overflow.
// Combinational decision on acc+step this cycle; clr_i zeroes acc and timer on the issue cycle.
module difftest_step_accum
    import difftest_sched_pkg::*;
#(
    parameter int STEP_WIDTH = 8,
    parameter int CNT_WIDTH  = 16,
    parameter int TO_WIDTH   = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  en_i,
    input  logic                  clr_i,
    input  logic [STEP_WIDTH-1:0] step_i,
    input  logic [CNT_WIDTH-1:0]  batch_thresh_i,
    input  logic [TO_WIDTH-1:0]   flush_timeout_i,
    output logic [CNT_WIDTH-1:0]  acc_count_o,
    output logic                  overflow_o,
    output logic                  flush_o
);

    logic [CNT_WIDTH-1:0] acc_q, acc_d;
    logic [TO_WIDTH-1:0]  idle_q, idle_d;
    logic [CNT_WIDTH:0]   acc_next;
    logic [CNT_WIDTH:0]   eff_thresh;
    logic                 thresh_hit;
    logic                 timeout_hit;

    // One extra bit so a wrap past the count width is visible as overflow.
    assign acc_next    = {1'b0, acc_q} + {{(CNT_WIDTH + 1 - STEP_WIDTH){1'b0}}, step_i};
    assign eff_thresh  = {1'b0, (batch_thresh_i == '0) ? CNT_WIDTH'(1) : batch_thresh_i};
    assign thresh_hit  = acc_next >= eff_thresh;
    assign timeout_hit = (flush_timeout_i != '0) && (idle_q >= flush_timeout_i)
                         && (acc_next != '0);

    assign acc_count_o = acc_next[CNT_WIDTH-1:0];
    assign overflow_o  = acc_next[CNT_WIDTH];
    assign flush_o     = thresh_hit || timeout_hit;

    always_comb begin
        acc_d  = acc_q;
        idle_d = idle_q;
        if (en_i) begin
            if (clr_i) begin
                acc_d  = '0;
                idle_d = '0;
            end else begin
                acc_d = acc_next[CNT_WIDTH-1:0];
                if (acc_q == '0) begin
                    idle_d = '0;
                end else if (idle_q != '1) begin
                    idle_d = idle_q + TO_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            acc_q  <= '0;
            idle_q <= '0;
        end else begin
            acc_q  <= acc_d;
            idle_q <= idle_d;
        end
    end

endmodule

// File: rtl/difftest_step_scheduler.sv
// Batches per-cycle commit steps into one-outstanding checker requests and tracks termination.
// Request issues the cycle after the batch decision; payload holds until req_valid && req_ready.
module difftest_step_scheduler
    import difftest_sched_pkg::*;
#(
    parameter int STEP_WIDTH = 8,
    parameter int CNT_WIDTH  = 16,
    parameter int TO_WIDTH   = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [STEP_WIDTH-1:0] step_in,
    input  logic [63:0]           max_cycles,
    input  logic [CNT_WIDTH-1:0]  batch_thresh,
    input  logic [TO_WIDTH-1:0]   flush_timeout,
    output logic                  init_valid,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic [CNT_WIDTH-1:0]  req_count,
    output logic [63:0]           req_cycle,
    input  logic                  rsp_valid,
    input  logic [31:0]           rsp_code,
    output logic [63:0]           n_cycles,
    output logic                  done,
    output logic [2:0]            done_cause
);

    sched_state_e         state_q, state_d;
    done_cause_e          cause_q, cause_d;
    logic [63:0]          n_cycles_q, n_cycles_d;
    logic [CNT_WIDTH-1:0] req_count_q, req_count_d;
    logic [63:0]          req_cycle_q, req_cycle_d;

    logic [CNT_WIDTH-1:0] acc_count;
    logic                 acc_ovf;
    logic                 acc_flush;
    logic                 acc_en;
    logic                 issue;
    logic                 ev_rsp;
    logic                 ev_fail;
    logic                 ev_gcpt;
    logic                 ev_max;

    assign acc_en  = (state_q != ST_DONE);
    assign ev_rsp  = (state_q == ST_WAIT_RSP) && rsp_valid;
    assign ev_fail = ev_rsp && (rsp_code != RSP_PASS) && (rsp_code != RSP_GCPT);
    assign ev_gcpt = ev_rsp && (rsp_code == RSP_GCPT);
    assign ev_max  = (max_cycles != 64'd0) && (n_cycles_q >= max_cycles);

    difftest_step_accum #(
        .STEP_WIDTH (STEP_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH),
        .TO_WIDTH   (TO_WIDTH)
    ) u_accum (
        .clock           (clock),
        .reset           (reset),
        .en_i            (acc_en),
        .clr_i           (issue),
        .step_i          (step_in),
        .batch_thresh_i  (batch_thresh),
        .flush_timeout_i (flush_timeout),
        .acc_count_o     (acc_count),
        .overflow_o      (acc_ovf),
        .flush_o         (acc_flush)
    );

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        issue   = 1'b0;
        if (state_q != ST_DONE) begin
            // Termination priority: fail > gcpt_limit > acc_overflow > max_cycles.
            if (ev_fail) begin
                state_d = ST_DONE;
                cause_d = CAUSE_FAIL;
            end else if (ev_gcpt) begin
                state_d = ST_DONE;
                cause_d = CAUSE_GCPT;
            end else if (acc_ovf) begin
                state_d = ST_DONE;
                cause_d = CAUSE_ACC_OVF;
            end else if (ev_max) begin
                state_d = ST_DONE;
                cause_d = CAUSE_MAX_CYCLES;
            end else begin
                case (state_q)
                    ST_INIT:     state_d = ST_RUN;
                    ST_RUN: begin
                        if (acc_flush) begin
                            state_d = ST_ISSUE;
                            issue   = 1'b1;
                        end
                    end
                    ST_ISSUE:    if (req_ready) state_d = ST_WAIT_RSP;
                    ST_WAIT_RSP: if (rsp_valid) state_d = ST_RUN;
                    default:     state_d = state_q;
                endcase
            end
        end
    end

    always_comb begin
        n_cycles_d  = n_cycles_q;
        req_count_d = req_count_q;
        req_cycle_d = req_cycle_q;
        // The counter stops on the cycle that decides DONE, so it reports the terminating cycle.
        if (state_q != ST_DONE && state_d != ST_DONE) begin
            n_cycles_d = n_cycles_q + 64'd1;
        end
        if (issue) begin
            req_count_d = acc_count;
            req_cycle_d = n_cycles_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= ST_INIT;
            cause_q     <= CAUSE_NONE;
            n_cycles_q  <= '0;
            req_count_q <= '0;
            req_cycle_q <= '0;
        end else begin
            state_q     <= state_d;
            cause_q     <= cause_d;
            n_cycles_q  <= n_cycles_d;
            req_count_q <= req_count_d;
            req_cycle_q <= req_cycle_d;
        end
    end

    // Gated by reset so the pulse only appears on the first cycle out of reset.
    assign init_valid = (state_q == ST_INIT) && reset;
    assign req_valid  = (state_q == ST_ISSUE);
    assign req_count  = req_count_q;
    assign req_cycle  = req_cycle_q;
    assign n_cycles   = n_cycles_q;
    assign done       = (state_q == ST_DONE);
    assign done_cause = cause_q;

endmodule

// File: tb/tb_difftest_step_scheduler.sv
// Directed self-checking bench for the difftest step scheduler.
module tb_difftest_step_scheduler;

    logic        clock;
    logic        reset;
    logic [7:0]  step_in;
    logic [63:0] max_cycles;
    logic [15:0] batch_thresh;
    logic [15:0] flush_timeout;
    logic        init_valid;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_count;
    logic [63:0] req_cycle;
    logic        rsp_valid;
    logic [31:0] rsp_code;
    logic [63:0] n_cycles;
    logic        done;
    logic [2:0]  done_cause;

    int checks = 0;
    int errors = 0;

    difftest_step_scheduler dut (
        .clock         (clock),
        .reset         (reset),
        .step_in       (step_in),
        .max_cycles    (max_cycles),
        .batch_thresh  (batch_thresh),
        .flush_timeout (flush_timeout),
        .init_valid    (init_valid),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_count     (req_count),
        .req_cycle     (req_cycle),
        .rsp_valid     (rsp_valid),
        .rsp_code      (rsp_code),
        .n_cycles      (n_cycles),
        .done          (done),
        .done_cause    (done_cause)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic apply_reset(input logic [63:0] maxc, input logic [15:0] thr, input logic [15:0] tmo);
        reset         = 1'b0;
        step_in       = '0;
        req_ready     = 1'b0;
        rsp_valid     = 1'b0;
        rsp_code      = '0;
        max_cycles    = maxc;
        batch_thresh  = thr;
        flush_timeout = tmo;
        repeat (3) @(negedge clock);
    endtask

    task automatic wait_req(input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clock);
            if (req_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clock);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic send_rsp(input logic [31:0] code);
        rsp_code  = code;
        rsp_valid = 1'b1;
        @(negedge clock);
        rsp_valid = 1'b0;
    endtask

    initial begin
        bit          ok;
        bit          init_again;
        bit          stable;
        int          rsp_timer;
        int          n_batches;
        int          step_sum;
        int          driven_total;
        logic [63:0] n0;
        logic [63:0] nfz;

        // Reset state and init pulse.
        apply_reset(64'd0, 16'd4, 16'd0);
        check_val("rst_init_valid", init_valid, 0);
        check_val("rst_req_valid", req_valid, 0);
        check_val("rst_done", done, 0);
        check_val("rst_cause", done_cause, 0);
        check_val("rst_n_cycles", n_cycles, 0);
        check_val("rst_req_count", req_count, 0);
        check_val("rst_req_cycle", req_cycle, 0);
        reset = 1'b1;
        #1;
        check_val("init_pulse", init_valid, 1);
        check_val("init_n_cycles", n_cycles, 0);
        @(negedge clock);
        check_val("init_drop", init_valid, 0);
        check_val("n_cycles_1", n_cycles, 1);

        // Steady batching: one step per cycle, threshold 4, pass two cycles after accept.
        req_ready    = 1'b1;
        init_again   = 1'b0;
        rsp_timer    = 0;
        n_batches    = 0;
        step_sum     = 0;
        driven_total = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clock);
            if (init_valid) init_again = 1'b1;
            rsp_valid = 1'b0;
            rsp_code  = 32'h0;
            if (rsp_timer > 0) begin
                rsp_timer--;
                if (rsp_timer == 0) rsp_valid = 1'b1;
            end
            if (req_valid && req_ready) begin
                step_sum += int'(req_count);
                n_batches++;
                check_val("batch_count_4", req_count, 4);
                rsp_timer = 2;
            end
            step_in = (i < 40) ? 8'd1 : 8'd0;
            driven_total += int'(step_in);
        end
        rsp_valid = 1'b0;
        check_val("step_sum", step_sum, driven_total);
        check_val("n_batches", n_batches, 10);
        check_val("init_once", init_again, 0);

        // Backpressure: request held 10 cycles while steps of 2 keep accumulating.
        req_ready = 1'b0;
        step_in   = 8'd4;
        @(negedge clock);
        check_val("bp_req_valid", req_valid, 1);
        check_val("bp_req_count", req_count, 4);
        step_in = 8'd2;
        stable  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (!req_valid || req_count != 16'd4) stable = 1'b0;
        end
        check_val("bp_payload_stable", stable, 1);
        step_in   = 8'd0;
        req_ready = 1'b1;
        @(negedge clock);
        req_ready = 1'b0;
        check_val("bp_accepted", req_valid, 0);
        send_rsp(32'h0);
        wait_req(6, ok);
        check_val("bp_next_req", ok, 1);
        check_val("bp_next_count", req_count, 20);
        req_ready = 1'b1;
        @(negedge clock);
        req_ready = 1'b0;
        send_rsp(32'h0);

        // Flush timeout: a lone step of 3 below threshold 100.
        apply_reset(64'd0, 16'd100, 16'd5);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        n0      = n_cycles;
        step_in = 8'd3;
        @(negedge clock);
        step_in = 8'd0;
        wait_req(20, ok);
        check_val("flush_req", ok, 1);
        check_val("flush_count", req_count, 3);
        check_val("flush_not_early", req_cycle >= n0 + 64'd5, 1);
        check_val("flush_not_late", req_cycle <= n0 + 64'd6, 1);
        req_ready = 1'b1;
        @(negedge clock);
        req_ready = 1'b0;
        send_rsp(32'hFF);
        check_val("gcpt_done", done, 1);
        check_val("gcpt_cause", done_cause, 2);
        check_val("gcpt_req_valid", req_valid, 0);
        nfz = n_cycles;
        repeat (5) @(negedge clock);
        check_val("gcpt_n_frozen", n_cycles, nfz);
        check_val("gcpt_done_sticky", done, 1);

        // Threshold 0 behaves as 1; mismatch verdict ends with cause 1.
        apply_reset(64'd0, 16'd0, 16'd0);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        step_in = 8'd1;
        @(negedge clock);
        step_in = 8'd0;
        check_val("thr0_req_valid", req_valid, 1);
        check_val("thr0_count", req_count, 1);
        req_ready = 1'b1;
        @(negedge clock);
        req_ready = 1'b0;
        send_rsp(32'h5);
        check_val("fail_done", done, 1);
        check_val("fail_cause", done_cause, 1);

        // Cycle limit with no traffic.
        apply_reset(64'd50, 16'd4, 16'd0);
        reset = 1'b1;
        wait_done(100, ok);
        check_val("max_done", ok, 1);
        check_val("max_cause", done_cause, 3);
        check_val("max_n_cycles", n_cycles, 50);

        // Mismatch on the same cycle the limit is hit: fail wins.
        apply_reset(64'd50, 16'd4, 16'd0);
        reset = 1'b1;
        @(negedge clock);
        step_in   = 8'd4;
        req_ready = 1'b1;
        @(negedge clock);
        step_in = 8'd0;
        @(negedge clock);
        req_ready = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (n_cycles == 64'd50) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        check_val("tie_reach_50", ok, 1);
        check_val("tie_not_done_yet", done, 0);
        send_rsp(32'h5);
        check_val("tie_done", done, 1);
        check_val("tie_cause", done_cause, 1);
        check_val("tie_n_cycles", n_cycles, 50);

        // Accumulator overflow while a request is stalled.
        apply_reset(64'd0, 16'd1, 16'd0);
        reset = 1'b1;
        @(negedge clock);
        step_in = 8'd1;
        @(negedge clock);
        step_in = 8'd255;
        wait_done(400, ok);
        step_in = 8'd0;
        check_val("ovf_done", ok, 1);
        check_val("ovf_cause", done_cause, 4);
        check_val("ovf_req_valid", req_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
